// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register: valid/ready handshake, two-entry skid buffer, synchronous flush.
// in_ready comes from stored state only, so MEM-stage stalls never form a combinational path into EXE.
module exe_mem_skid_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  WB_en_in,
  input  logic                  MEM_R_EN_in,
  input  logic                  MEM_W_EN_in,
  input  logic [DATA_W-1:0]     ALU_result_in,
  input  logic [DATA_W-1:0]     ST_val_in,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  WB_en,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic [DATA_W-1:0]     ALU_result,
  output logic [DATA_W-1:0]     ST_val,
  output logic [REG_ADDR_W-1:0] Dest,
  output logic [1:0]            occupancy
);

  localparam int ENT_W = 3 + 2 * DATA_W + REG_ADDR_W;

  logic [ENT_W-1:0] head_q;
  logic [ENT_W-1:0] skid_q;
  logic [ENT_W-1:0] in_ent;
  logic             head_valid;
  logic             skid_valid;
  logic             accept;
  logic             drain;
  logic             head_wb;
  logic             head_mr;
  logic             head_mw;

  assign in_ent    = {WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in};
  assign in_ready  = !skid_valid && !rst;
  assign out_valid = head_valid;
  assign accept    = in_valid && in_ready;
  assign drain     = head_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!head_valid || drain) begin
      // Head is free this cycle: the older skid entry always goes first.
      if (skid_valid) begin
        head_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        head_q     <= in_ent;
        head_valid <= 1'b1;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_ent;
      skid_valid <= 1'b1;
    end
  end

  assign {head_wb, head_mr, head_mw, ALU_result, ST_val, Dest} = head_q;

  // Bubbles must never write memory or the register file.
  assign WB_en    = head_wb && head_valid;
  assign MEM_R_EN = head_mr && head_valid;
  assign MEM_W_EN = head_mw && head_valid;

  assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Randomised and directed bench for exe_mem_skid_reg against a FIFO-queue reference model.
// A second instance with wide parameters checks that data passes through untruncated.
module tb_exe_mem_skid_reg;

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        WB_en_in = 1'b0, MEM_R_EN_in = 1'b0, MEM_W_EN_in = 1'b0;
  logic [31:0] ALU_result_in = '0, ST_val_in = '0;
  logic [3:0]  Dest_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        WB_en, MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_result, ST_val;
  logic [3:0]  Dest;
  logic [1:0]  occupancy;

  logic        w_flush = 1'b0, w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b1;
  logic        w_wb, w_mr, w_mw;
  logic [63:0] w_alu_in = '0, w_st_in = '0, w_alu, w_st;
  logic [4:0]  w_dest_in = '0, w_dest;
  logic [1:0]  w_occ;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  exe_mem_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in), .Dest_in(Dest_in),
    .out_valid(out_valid), .out_ready(out_ready), .WB_en(WB_en), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .ALU_result(ALU_result), .ST_val(ST_val), .Dest(Dest),
    .occupancy(occupancy)
  );

  exe_mem_skid_reg #(.DATA_W(64), .REG_ADDR_W(5)) dut_wide (
    .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .WB_en_in(1'b1), .MEM_R_EN_in(1'b0), .MEM_W_EN_in(1'b0),
    .ALU_result_in(w_alu_in), .ST_val_in(w_st_in), .Dest_in(w_dest_in),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .WB_en(w_wb), .MEM_R_EN(w_mr),
    .MEM_W_EN(w_mw), .ALU_result(w_alu), .ST_val(w_st), .Dest(w_dest),
    .occupancy(w_occ)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.wb   = 1'($urandom);
    e.mr   = 1'($urandom);
    e.mw   = 1'($urandom);
    e.alu  = $urandom;
    e.st   = $urandom;
    e.dest = 4'($urandom);
    return e;
  endfunction

  function automatic ent_t mk(input logic [31:0] alu);
    ent_t e;
    e = rand_ent();
    e.alu = alu;
    return e;
  endfunction

  task automatic check_outputs(input logic r);
    check("out_valid", out_valid, q.size() > 0);
    check("occupancy", occupancy, q.size());
    check("in_ready", in_ready, (q.size() < 2) && !r);
    if (q.size() > 0) begin
      check("WB_en", WB_en, q[0].wb);
      check("MEM_R_EN", MEM_R_EN, q[0].mr);
      check("MEM_W_EN", MEM_W_EN, q[0].mw);
      check("ALU_result", ALU_result, q[0].alu);
      check("ST_val", ST_val, q[0].st);
      check("Dest", Dest, q[0].dest);
    end else begin
      check("WB_en_gated", WB_en, 0);
      check("MEM_R_EN_gated", MEM_R_EN, 0);
      check("MEM_W_EN_gated", MEM_W_EN, 0);
    end
    if (r) begin
      check("rst_alu", ALU_result, 0);
      check("rst_st", ST_val, 0);
      check("rst_dest", Dest, 0);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input logic iv, input ent_t e, input logic ordy, input logic fl, input logic r);
    logic acc, drn;
    in_valid = iv;
    WB_en_in = e.wb; MEM_R_EN_in = e.mr; MEM_W_EN_in = e.mw;
    ALU_result_in = e.alu; ST_val_in = e.st; Dest_in = e.dest;
    out_ready = ordy; flush = fl; rst = r;
    #1;
    check("in_ready_pre", in_ready, (q.size() < 2) && !r);
    @(posedge clk);
    acc = iv && (q.size() < 2) && !r;
    drn = (q.size() > 0) && ordy;
    if (r || fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    check_outputs(r);
  endtask

  initial begin
    ent_t e;
    @(negedge clk);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);

    // Streaming at full rate
    cyc(1, mk(32'h10), 1, 0, 0); check("stream0", ALU_result, 32'h10);
    cyc(1, mk(32'h20), 1, 0, 0); check("stream1", ALU_result, 32'h20);
    cyc(1, mk(32'h30), 1, 0, 0); check("stream2", ALU_result, 32'h30);
    check("stream_rdy", in_ready, 1);
    cyc(0, '0, 1, 0, 0); check("stream_empty", out_valid, 0);

    // Stall absorb and release
    cyc(1, mk(32'h11), 0, 0, 0);
    cyc(1, mk(32'h22), 0, 0, 0);
    check("absorb_occ", occupancy, 2); check("absorb_rdy", in_ready, 0);
    check("absorb_head", ALU_result, 32'h11);
    cyc(1, mk(32'h33), 0, 0, 0); check("stall_hold", ALU_result, 32'h11);
    cyc(0, '0, 1, 0, 0); check("release_b", ALU_result, 32'h22); check("release_rdy", in_ready, 1);
    cyc(0, '0, 1, 0, 0); check("release_empty", occupancy, 0);

    // Flush with a full buffer and a pending input
    cyc(1, mk(32'hA1), 0, 0, 0);
    cyc(1, mk(32'hA2), 0, 0, 0);
    e = mk(32'hA3); e.wb = 1; e.mw = 1;
    cyc(1, e, 0, 1, 0);
    check("flush_valid", out_valid, 0); check("flush_occ", occupancy, 0);
    check("flush_wb", WB_en, 0); check("flush_mw", MEM_W_EN, 0); check("flush_rdy", in_ready, 1);
    cyc(0, '0, 1, 0, 0); check("flush_gone", out_valid, 0);

    // Bubbles never raise control outputs
    e = mk(32'h55); e.wb = 1; e.mw = 1;
    repeat (3) begin
      cyc(0, e, 1, 0, 0);
      check("bubble_wb", WB_en, 0); check("bubble_mw", MEM_W_EN, 0); check("bubble_occ", occupancy, 0);
    end

    // Reset during a stall
    cyc(1, mk(32'hB1), 0, 0, 0);
    cyc(1, mk(32'hB2), 0, 0, 0);
    cyc(1, mk(32'hB3), 1, 0, 1);
    check("rst_valid", out_valid, 0); check("rst_occ", occupancy, 0); check("rst_rdy", in_ready, 0);
    rst = 0; #1; check("rst_release_rdy", in_ready, 1);
    cyc(0, '0, 1, 0, 0); check("rst_gone", out_valid, 0);

    // Wide instance: no truncation
    w_in_valid = 1; w_alu_in = 64'hDEADBEEF_CAFEF00D; w_dest_in = 5'd31; w_st_in = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); @(negedge clk);
    w_in_valid = 0;
    check("wide_valid", w_out_valid, 1);
    check("wide_alu", w_alu, 64'hDEADBEEF_CAFEF00D);
    check("wide_st", w_st, 64'h0123_4567_89AB_CDEF);
    check("wide_dest", w_dest, 5'd31);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), rand_ent(), 1'($urandom_range(0, 9) < 6),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exe_mem_skid_reg.md
# exe_mem_skid_reg

Parametrised EXE→MEM pipeline register with valid/ready flow control, a two-entry skid buffer, and a synchronous flush. It sits between the execute stage and the memory stage and carries the write-back, memory-read and memory-write enables, the ALU result, the store value and the destination register. Unlike a plain per-cycle register, it absorbs memory-stage stalls without a combinational ready path back into EXE. It also squashes wrong-path instructions on flush.

## Interface
Parameters:
- DATA_W, 32, width of ALU_result and ST_val.
- REG_ADDR_W, 4, width of Dest.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  squash all held and incoming entries.
- in_valid  in  1  EXE presents a valid instruction.
- in_ready  out  1  block can accept this cycle.
- WB_en_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control fields.
- ALU_result_in  in  DATA_W  ALU result or address.
- ST_val_in  in  DATA_W  store data.
- Dest_in  in  REG_ADDR_W  destination register.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM stage consumes the entry this cycle.
- WB_en, MEM_R_EN, MEM_W_EN  out  1 each  control fields, ANDed with out_valid.
- ALU_result, ST_val  out  DATA_W  head-entry data, ungated.
- Dest  out  REG_ADDR_W  head-entry destination, ungated.
- occupancy  out  2  number of valid entries, 0..2.

## Operation
- State: head entry (drives outputs) plus skid entry. Each entry has a valid bit and a full copy of all fields.
- Transfer definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- in_ready = !skid_valid & !rst. It is registered state only and has no combinational dependence on out_ready.
- out_valid = head_valid.
- Next-state rules when flush=0; order is always preserved:
  - head empty, accept: head ← input.
  - head full, drain, skid empty, accept: head ← input.
  - head full, drain, skid empty, no accept: head empties.
  - head full, no drain, accept: skid ← input.
  - head full, drain, skid full: head ← skid, skid empties. No accept is possible because in_ready=0.
  - head full, no drain, skid full: hold all state.
- flush=1:
  - Both valid bits clear next cycle.
  - An accept in the same cycle is discarded.
  - A drain in the same cycle still counts as completed.
  - Data fields are don't-care after flush; the control outputs read 0 through gating.
- Control gating: WB_en, MEM_R_EN and MEM_W_EN are 0 whenever out_valid=0, so bubbles never write memory or the register file.
- occupancy = head_valid + skid_valid. The state skid_valid=1 with head_valid=0 is unreachable.
- MEM_R_EN and MEM_W_EN both set is passed through unchanged; the block does not check it.

## Timing
- Reset, when rst is high at a rising edge:
  - Both valid bits become 0.
  - All stored fields become 0.
  - All outputs read 0, including occupancy.
  - in_ready reads 0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-operation discards both entries. rst has priority over flush and over all transfers.
- Latency: an accept at edge N makes the data visible with out_valid=1 after edge N, when the head was empty or draining.
- Throughput: 1 instruction/cycle with out_ready held at 1.
- Backpressure:
  - out_ready falls: the block absorbs one further instruction into the skid, then deasserts in_ready at the next edge.
  - out_ready rises: the skid moves to the head first; in_ready reasserts one cycle later.
- Outputs are stable while out_valid=1 and out_ready=0.

## Test plan
- Streaming: out_ready=1, send ALU_result_in=0x10,0x20,0x30 on consecutive cycles → out_valid on the 3 following cycles with the same values in order; occupancy stays ≤1; in_ready stays 1.
- Stall absorb:
  - Head holds A=0x11 and out_ready=0.
  - Send B=0x22 → skid loads B, occupancy=2, in_ready=0 next cycle, outputs stay at A.
  - Raise out_ready → A, then B, appear on consecutive cycles.
  - in_ready returns to 1 the cycle after A drains.
- Flush:
  - With occupancy=2 and in_valid=1, pulse flush → next cycle out_valid=0, occupancy=0, WB_en=MEM_W_EN=0, in_ready=1.
  - The incoming instruction never appears on the outputs.
- Bubble gating: feed in_valid=0 with WB_en_in=1 and MEM_W_EN_in=1 → WB_en and MEM_W_EN stay 0 and occupancy stays 0.
- Reset mid-stall:
  - With occupancy=2, assert rst for 1 cycle → all outputs read 0 and in_ready=0 during rst.
  - The cycle after rst falls, in_ready=1; the old entries never reappear.
- Width parameter: DATA_W=64, REG_ADDR_W=5; send ALU_result_in=0xDEADBEEF_CAFEF00D and Dest_in=31 → both pass through exactly with no truncation.
